uart_tx: RTL and testbench
==========================

# uart_tx

Byte-serializing 8N1 UART transmitter for the USB3300 sniffer on the ICEstick. It accepts captured bytes from the upstream capture/FIFO logic over a valid/ready handshake and shifts them out LSB-first on the FTDI serial line. The frame is one start bit, eight data bits and one stop bit, with no parity. It is the stage that consumes parallel bytes and turns them into the host-visible serial stream.

## Interface
- BAUD_DIV, 104: clock cycles per bit (12 MHz / 115200). Legal range ≥ 2.
- clk  in  1  system clock, single domain
- rst  in  1  synchronous reset, active-high
- data_in  in  8  byte to send; sampled only on accept
- data_valid  in  1  upstream has a byte on data_in
- data_ready  out  1  block can accept a byte this cycle
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress (state ≠ IDLE)

## Operation
- States: IDLE, START, DATA, STOP.
- Accept event: data_valid && data_ready, on a rising clk. On accept:
  - data_in is latched into an internal 8-bit shift register.
  - The bit index is cleared to 0.
  - The baud counter is cleared to 0.
  - The state goes to START.
- data_ready = 1 only in IDLE. Once accepted, later data_in or data_valid changes do not affect the frame.
- Baud counter:
  - Counts 0..BAUD_DIV-1 in START, DATA and STOP. Held at 0 in IDLE.
  - Width $clog2(BAUD_DIV).
  - bit_end = (counter == BAUD_DIV-1). The counter wraps to 0 on bit_end.
- START: tx = 0. On bit_end, go to DATA.
- DATA: tx = shift register bit 0.
  - On bit_end, shift right by one and increment the bit index.
  - When bit index 7 ends, go to STOP.
- STOP: tx = 1. On bit_end, go to IDLE.
- IDLE: tx = 1, busy = 0.
- tx is registered (no glitches). busy and data_ready are registered or decoded from the state register only.
- Reset (any state, mid-frame included): on the next edge, state = IDLE, tx = 1, busy = 0, data_ready = 0, counter = 0, bit index = 0.
  - The aborted byte is dropped; it is not resumed.
- After reset deasserts, data_ready = 1 from the first clock edge with rst low.
- rst together with data_valid: reset wins and nothing is accepted.

## Timing
- Reset values: tx = 1, busy = 0, data_ready = 0.
- Accept at edge N:
  - tx falls to 0 at edge N+1 (one cycle latency).
  - busy = 1 and data_ready = 0 from edge N+1.
- Each bit is exactly BAUD_DIV cycles wide. A frame is 10·BAUD_DIV cycles from the tx falling edge to the end of the stop bit.
- After the stop bit completes, the state is IDLE and data_ready = 1 for at least one cycle.
  - Minimum accept-to-accept spacing is 10·BAUD_DIV + 1 cycles.
  - A continuously asserted data_valid gives back-to-back frames separated by exactly one idle-high cycle.
- data_valid while busy is ignored and not queued. Upstream must hold data_valid until data_ready.

## Structure
- Shared package `uart_pkg`:
  - State encoding (2-bit localparams for IDLE/START/DATA/STOP).
  - DEFAULT_BAUD_DIV = 104.
  - Frame constants: DATA_BITS = 8, FRAME_BITS = 10.
- One natural sub-module: `baud_tick`.
  - Parameterized counter with inputs clk, rst, en, clr and output tick.
  - Reusable by a future uart_rx.
- The shift register and FSM stay inline.

## Test plan
Run with BAUD_DIV = 4 unless noted.
- Reset, then idle: after rst is released → tx = 1, busy = 0, data_ready = 1; no tx transitions for 100 cycles.
- Single byte 0xA5 pulsed valid for 1 cycle → tx samples every 4 cycles read 0,1,0,1,0,0,1,0,1,1. busy stays high for 40 cycles. data_ready returns high.
- Back-to-back 0x00 then 0xFF with data_valid held high → two frames, 40 cycles each, separated by exactly one tx = 1 cycle. Second frame data bits are all 1.
- data_in changed to 0x3C while sending 0x81 → the line still carries 0x81. The data_valid pulse during busy produces no extra frame.
- rst asserted during DATA bit 3 of 0xF0 → tx = 1 and busy = 0 on the next edge. A subsequent 0x55 is transmitted intact.
- BAUD_DIV = 2 (minimum): 0x01 → frame is 20 cycles; bit widths are exactly 2 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART blocks.
// Used by the transmitter today and a future receiver.
package uart_pkg;

    localparam int DEFAULT_BAUD_DIV = 104;
    localparam int DATA_BITS        = 8;
    localparam int FRAME_BITS       = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte valid/ready handshake between the capture FIFO and
// the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_tx_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 while enabled and
// flags the last cycle of each bit.
module baud_tick #(
    parameter int DIV = 104
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte over valid/ready and
// shifts it out LSB-first with one start and one stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       i_clk,
    input  logic       i_rst,
    uart_tx_if.slave   s_up,
    output logic       o_tx,
    output logic       o_busy
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  w_shift_nxt;
    logic [2:0]            r_idx;
    logic [2:0]            w_idx_nxt;
    logic                  r_tx;
    logic                  w_tx_nxt;
    logic                  r_ready;
    logic                  w_accept;
    logic                  w_en;
    logic                  w_tick;

    assign w_accept = s_up.valid && r_ready;
    assign w_en     = (r_state != IDLE);

    baud_tick #(
        .DIV (BAUD_DIV)
    ) u_baud (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_en),
        .i_clr  (w_accept),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = START;
                    w_shift_nxt = s_up.data;
                    w_idx_nxt   = '0;
                end
            end
            START: begin
                if (w_tick) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'(DATA_BITS - 1)) w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_tick) w_state_nxt = IDLE;
            end
        endcase
        // Line level is computed from the next state so tx is a clean flop.
        w_tx_nxt = 1'b1;
        if (w_state_nxt == START) begin
            w_tx_nxt = 1'b0;
        end else if (w_state_nxt == DATA) begin
            w_tx_nxt = w_shift_nxt[0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            r_ready <= (w_state_nxt == IDLE);
        end
    end

    assign o_tx       = r_tx;
    assign o_busy     = (r_state != IDLE);
    assign s_up.ready = r_ready;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames plus random traffic on a
// BAUD_DIV=4 and a BAUD_DIV=2 instance, checked every cycle.
module tb_uart_tx;

    localparam int B0 = 4;
    localparam int B1 = 2;

    logic       clk = 1'b0;
    logic       v_rst[2];
    logic       v_valid[2];
    logic [7:0] v_data[2];
    logic       w_tx[2];
    logic       w_busy[2];
    logic       w_rdy[2];

    int checks = 0;
    int errors = 0;

    logic       m_act[2];
    logic       m_rdy[2];
    int         m_k[2];
    logic [9:0] m_frame[2];

    always #5 clk = ~clk;

    uart_tx_if u_if4 ();
    uart_tx_if u_if2 ();

    assign u_if4.data  = v_data[0];
    assign u_if4.valid = v_valid[0];
    assign w_rdy[0]    = u_if4.ready;
    assign u_if2.data  = v_data[1];
    assign u_if2.valid = v_valid[1];
    assign w_rdy[1]    = u_if2.ready;

    uart_tx #(.BAUD_DIV(B0)) u_dut4 (
        .i_clk  (clk),
        .i_rst  (v_rst[0]),
        .s_up   (u_if4),
        .o_tx   (w_tx[0]),
        .o_busy (w_busy[0])
    );

    uart_tx #(.BAUD_DIV(B1)) u_dut2 (
        .i_clk  (clk),
        .i_rst  (v_rst[1]),
        .s_up   (u_if2),
        .o_tx   (w_tx[1]),
        .o_busy (w_busy[1])
    );

    function automatic int bd(int c);
        return (c == 0) ? B0 : B1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a frame is 10*B cycles, frame bit k/B is on the line.
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (v_rst[c]) begin
                m_act[c] <= 1'b0;
                m_k[c]   <= 0;
                m_rdy[c] <= 1'b0;
            end else if (m_act[c]) begin
                if (m_k[c] == 10 * bd(c) - 1) begin
                    m_act[c] <= 1'b0;
                    m_k[c]   <= 0;
                    m_rdy[c] <= 1'b1;
                end else begin
                    m_k[c] <= m_k[c] + 1;
                end
            end else if (m_rdy[c] && v_valid[c]) begin
                m_act[c]   <= 1'b1;
                m_k[c]     <= 0;
                m_frame[c] <= {1'b1, v_data[c], 1'b0};
                m_rdy[c]   <= 1'b0;
            end else begin
                m_rdy[c] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            automatic logic e_tx = 1'b1;
            if (m_act[c]) e_tx = m_frame[c][m_k[c] / bd(c)];
            chk($sformatf("tx%0d", c), 32'(w_tx[c]), 32'(e_tx));
            chk($sformatf("busy%0d", c), 32'(w_busy[c]), 32'(m_act[c]));
            chk($sformatf("ready%0d", c), 32'(w_rdy[c]), 32'(m_rdy[c]));
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(int c, logic [7:0] d, bit hold);
        int n;
        n = 0;
        v_valid[c] = 1'b1;
        v_data[c]  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_act[c] && m_k[c] == 0) && n < 500);
        if (!hold) v_valid[c] = 1'b0;
        chk($sformatf("accept_busy%0d", c), 32'(w_busy[c]), 32'd1);
    endtask

    task automatic measure(int c, output int len, output logic [9:0] bits);
        int b;
        b    = bd(c);
        len  = 0;
        bits = '0;
        while (w_busy[c] && len < 200) begin
            if ((len % b) == b / 2 && (len / b) < 10) bits[len / b] = w_tx[c];
            len++;
            @(negedge clk);
        end
    endtask

    task automatic count_idle(int c, output int g);
        g = 0;
        while (!w_busy[c] && g < 200) begin
            g++;
            @(negedge clk);
        end
    endtask

    task automatic rand_traffic(int c, int cycles);
        for (int i = 0; i < cycles; i++) begin
            v_valid[c] = ($urandom_range(0, 3) != 0);
            v_data[c]  = 8'($urandom);
            v_rst[c]   = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        v_valid[c] = 1'b0;
        v_rst[c]   = 1'b0;
        step(10 * bd(c) + 5);
    endtask

    task automatic seq0();
        int         len;
        int         g;
        int         tr;
        logic       prev;
        logic [9:0] bits;
        v_rst[0] = 1'b1;
        step(3);
        chk("rst_tx", 32'(w_tx[0]), 32'd1);
        chk("rst_busy", 32'(w_busy[0]), 32'd0);
        chk("rst_ready", 32'(w_rdy[0]), 32'd0);
        v_rst[0] = 1'b0;
        step(1);
        chk("rel_ready", 32'(w_rdy[0]), 32'd1);
        tr   = 0;
        prev = w_tx[0];
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (w_tx[0] != prev) tr++;
            prev = w_tx[0];
        end
        chk("idle_edges", 32'(tr), 32'd0);

        send(0, 8'hA5, 1'b0);
        measure(0, len, bits);
        chk("a5_len", 32'(len), 32'd40);
        chk("a5_bits", 32'(bits), 32'h34A);
        chk("a5_ready", 32'(w_rdy[0]), 32'd1);

        step(5);
        send(0, 8'h00, 1'b1);
        v_data[0] = 8'hFF;
        measure(0, len, bits);
        chk("b2b0_len", 32'(len), 32'd40);
        chk("b2b0_bits", 32'(bits), 32'h200);
        count_idle(0, g);
        v_valid[0] = 1'b0;
        chk("b2b_gap", 32'(g), 32'd1);
        measure(0, len, bits);
        chk("b2b1_len", 32'(len), 32'd40);
        chk("b2b1_bits", 32'(bits), 32'h3FE);

        step(5);
        send(0, 8'h81, 1'b0);
        len  = 0;
        bits = '0;
        while (w_busy[0] && len < 200) begin
            if (len == 1) v_data[0] = 8'h3C;
            if (len == 8) v_valid[0] = 1'b1;
            if (len == 11) v_valid[0] = 1'b0;
            if ((len % B0) == B0 / 2 && (len / B0) < 10) bits[len / B0] = w_tx[0];
            len++;
            @(negedge clk);
        end
        chk("hold_bits", 32'(bits), 32'h302);
        g = 0;
        for (int i = 0; i < 60; i++) begin
            if (w_busy[0]) g++;
            step(1);
        end
        chk("no_extra", 32'(g), 32'd0);

        send(0, 8'hF0, 1'b0);
        step(17);
        v_rst[0] = 1'b1;
        step(1);
        chk("abort_tx", 32'(w_tx[0]), 32'd1);
        chk("abort_busy", 32'(w_busy[0]), 32'd0);
        chk("abort_ready", 32'(w_rdy[0]), 32'd0);
        v_rst[0] = 1'b0;
        step(1);
        chk("abort_rel", 32'(w_rdy[0]), 32'd1);
        send(0, 8'h55, 1'b0);
        measure(0, len, bits);
        chk("x55_len", 32'(len), 32'd40);
        chk("x55_bits", 32'(bits), 32'h2AA);

        rand_traffic(0, 1500);
    endtask

    task automatic seq1();
        int         len;
        logic [9:0] bits;
        v_rst[1] = 1'b1;
        step(3);
        v_rst[1] = 1'b0;
        step(1);
        chk("d2_ready", 32'(w_rdy[1]), 32'd1);
        send(1, 8'h01, 1'b0);
        measure(1, len, bits);
        chk("d2_len", 32'(len), 32'd20);
        chk("d2_bits", 32'(bits), 32'h202);
        rand_traffic(1, 1500);
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            v_rst[c]   = 1'b1;
            v_valid[c] = 1'b0;
            v_data[c]  = 8'h00;
            m_act[c]   = 1'b0;
            m_rdy[c]   = 1'b0;
            m_k[c]     = 0;
            m_frame[c] = '1;
        end
        fork
            seq0();
            seq1();
        join
        step(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
